n64_apb_regs: RTL and testbench

N64_APB_REGS -- requirements
Module: n64_apb_regs

---
 rtl/n64_apb_pkg.sv | 30 +++
 rtl/n64_sample_fifo.sv | 77 +++++++
 rtl/n64_apb_regs.sv | 194 +++++++++++++++++++
 tb/tb_n64_apb_regs.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_apb_pkg.sv
// Shared definitions for the N64 controller APB register block.
// Holds the register index map (PADDR[4:2]), field bit positions and the
// APB access state enumeration used by the responder FSM.
package n64_apb_pkg;

    // Register index as seen on PADDR[4:2]
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_DATA     = 3'd2;
    localparam logic [2:0] REG_POLL_DIV = 3'd3;

    // CTRL fields
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    // STATUS fields
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 4;

    // APB responder access states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } apb_state_e;

endpackage

// File: rtl/n64_sample_fifo.sv
// Sample FIFO for controller samples pushed from fabric logic.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wdata       write request and data (ignored when full unless popping)
//   pop               remove head (ignored when empty)
//   flush             empty the FIFO; overrides push and pop in the same cycle
//   empty, full       occupancy flags
//   count             number of stored entries (0..DEPTH)
//   head              data at the read pointer, valid while !empty
module n64_sample_fifo
    import n64_apb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty && !flush;
        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        do_push  = push && !flush && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/n64_apb_regs.sv
// APB3 responder exposing the N64 controller sample path to the MSS.
// Registers (PADDR[4:2]): CTRL (RW), STATUS (RO + W1C overflow),
// DATA (RO, pops the sample FIFO, one wait state), POLL_DIV (RW).
// Ports:
//   PCLK, PRESETn                 clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB3 request
//   PRDATA/PREADY/PSLVERR         APB3 response (valid only while PREADY=1)
//   sample_valid, sample_data     one-cycle sample push from fabric
//   poll_tick                     one-cycle poll request pulse
//   irq                           level interrupt to FABINT
//   dbg_state                     current access FSM state
//
// Handshake: a transfer is a setup cycle (PSEL & !PENABLE) followed by an
// access phase; the transfer completes on the rising edge where
// PSEL & PENABLE & PREADY. Writes commit and DATA pops happen only on that
// completing edge; PRDATA/PSLVERR are zero whenever PREADY is low.
module n64_apb_regs
    import n64_apb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              sample_valid,
    input  logic [31:0]       sample_data,
    output logic              poll_tick,
    output logic              irq,
    output apb_state_e        dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    apb_state_e    state_q, state_d;
    logic          enable_q, enable_d;
    logic          irq_en_q, irq_en_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;
    logic          poll_tick_q, poll_tick_d;
    logic [15:0]   period_q, period_d;
    logic [15:0]   poll_cnt_q, poll_cnt_d;

    logic [2:0]    reg_idx;
    logic          mapped, is_data;
    logic          wr_done, pop_req;
    logic          ctrl_wr, status_wr, poll_wr, flush, push_req, ovf_set;
    logic [31:0]   rd_mux, status_word;

    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head;

    logic          unused_bits;
    assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

    assign reg_idx = PADDR[4:2];
    assign mapped  = (PADDR[ADDR_W-1:5] == '0) && !reg_idx[2];
    assign is_data = mapped && (reg_idx == REG_DATA);

    assign status_word = {23'd0, 5'(fifo_count), 1'b0, ovf_q, fifo_full, fifo_empty};

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            REG_CTRL:     rd_mux = {29'd0, 1'b0, irq_en_q, enable_q};
            REG_STATUS:   rd_mux = status_word;
            REG_POLL_DIV: rd_mux = {16'd0, period_q};
            default:      rd_mux = '0;
        endcase
    end

    // Access FSM. DATA reads take one extra cycle so the pop and the returned
    // head are both decided in the WAIT cycle; everything else is zero-wait.
    always_comb begin
        state_d = state_q;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        wr_done = 1'b0;
        pop_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (PSEL && PENABLE) begin
                    if (is_data && !PWRITE) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                        PREADY  = 1'b1;
                        if (!mapped || is_data) PSLVERR = 1'b1;
                        else if (PWRITE)        wr_done = 1'b1;
                        else                    PRDATA  = rd_mux;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                state_d = S_IDLE;
                PREADY  = 1'b1;
                if (fifo_empty) begin
                    PSLVERR = 1'b1;
                end else begin
                    pop_req = 1'b1;
                    PRDATA  = fifo_head;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ctrl_wr   = wr_done && (reg_idx == REG_CTRL);
    assign status_wr = wr_done && (reg_idx == REG_STATUS);
    assign poll_wr   = wr_done && (reg_idx == REG_POLL_DIV);
    assign flush     = ctrl_wr && PWDATA[CTRL_FLUSH_BIT];
    assign push_req  = sample_valid && enable_q;
    // A push is lost only when full with no pop; a flush drops it silently.
    assign ovf_set   = push_req && fifo_full && !pop_req && !flush;

    always_comb begin
        enable_d    = ctrl_wr ? PWDATA[CTRL_ENABLE_BIT] : enable_q;
        irq_en_d    = ctrl_wr ? PWDATA[CTRL_IRQ_EN_BIT] : irq_en_q;
        period_d    = poll_wr ? PWDATA[15:0] : period_q;
        ovf_d       = ovf_q;
        if (status_wr && PWDATA[STAT_OVF_BIT]) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;   // a new overflow wins over a clear

        poll_tick_d = 1'b0;
        poll_cnt_d  = poll_cnt_q;
        if (!enable_q || poll_wr || (ctrl_wr && !PWDATA[CTRL_ENABLE_BIT]) || period_q == '0) begin
            poll_cnt_d = '0;
        end else if (poll_cnt_q == period_q) begin
            poll_cnt_d  = '0;
            poll_tick_d = 1'b1;
        end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
        end

        irq_d = irq_en_q && (!fifo_empty || ovf_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            poll_tick_q <= 1'b0;
            period_q    <= '0;
            poll_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
            poll_tick_q <= poll_tick_d;
            period_q    <= period_d;
            poll_cnt_q  <= poll_cnt_d;
        end
    end

    assign irq       = irq_q;
    assign poll_tick = poll_tick_q;
    assign dbg_state = state_q;

    n64_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (push_req),
        .wdata (sample_data),
        .pop   (pop_req),
        .flush (flush),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_n64_apb_regs.sv
// Self-checking bench for n64_apb_regs: directed steps plus a randomized
// push/pop/status phase checked against a queue-based model.
module tb_n64_apb_regs;
    import n64_apb_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b1;
    logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [AW-1:0] PADDR = '0;
    logic [31:0]   PWDATA = '0;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;
    logic          sample_valid = 1'b0;
    logic [31:0]   sample_data = '0;
    logic          poll_tick, irq;
    apb_state_e    dbg_state;

    // clock / watchdog
    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    n64_apb_regs #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .sample_valid(sample_valid),
        .sample_data(sample_data), .poll_tick(poll_tick), .irq(irq),
        .dbg_state(dbg_state)
    );

    // reference model
    logic [31:0] exp_q[$];
    logic        m_en, m_irq_en, m_ovf;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic logic [31:0] exp_status();
        int n;
        n = exp_q.size();
        return {23'd0, 5'(n), 1'b0, m_ovf, (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic exp_irq();
        return m_irq_en && (exp_q.size() != 0 || m_ovf);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_en = 0; m_irq_en = 0; m_ovf = 0;
    endtask

    task automatic model_push(input logic [31:0] d);
        if (m_en) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else m_ovf = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    // One APB transfer; optional sample push lands in the completing cycle.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       input logic push_en, input logic [31:0] pd,
                       output logic [31:0] rd, output logic err, output int waits);
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1;
        #1;
        waits = 0;
        while (!PREADY && waits < 8) begin
            @(negedge PCLK);
            #1;
            waits++;
        end
        rd = PRDATA; err = PSLVERR;
        sample_valid = push_en; sample_data = pd;
        @(posedge PCLK);
        #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0; sample_valid = 0;
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] addr, input logic [31:0] wd,
                          input logic e_err);
        logic [31:0] rd; logic err; int w;
        apb(1, addr, wd, 0, 0, rd, err, w);
        check({tag, "_err"}, err, e_err);
        check({tag, "_rdata"}, rd, 0);
        check({tag, "_wait"}, w, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] e_d,
                          input logic e_err, input int e_w);
        logic [31:0] rd; logic err; int w;
        apb(0, addr, 0, 0, 0, rd, err, w);
        check({tag, "_data"}, rd, e_d);
        check({tag, "_err"}, err, e_err);
        check({tag, "_wait"}, w, e_w);
    endtask

    // DATA read with expectation taken from the model
    task automatic rd_data(input string tag);
        logic [31:0] e_d; logic e_err;
        if (exp_q.size() == 0) begin e_err = 1; e_d = 0; end
        else begin e_err = 0; e_d = exp_q.pop_front(); end
        rd_chk(tag, 8'h08, e_d, e_err, 1);
    endtask

    task automatic push_sample(input logic [31:0] d);
        @(negedge PCLK);
        sample_valid = 1; sample_data = d;
        @(negedge PCLK);
        sample_valid = 0;
        model_push(d);
    endtask

    task automatic count_ticks(input int ncyc, output int nt, output int bad_gap, input int gap);
        int last;
        nt = 0; bad_gap = 0; last = -1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge PCLK);
            if (poll_tick) begin
                if (last >= 0 && (i - last) != gap) bad_gap++;
                last = i;
                nt++;
            end
        end
    endtask

    task automatic irq_chk(input string tag);
        repeat (2) @(negedge PCLK);
        check(tag, irq, exp_irq());
    endtask

    // directed sequence
    initial begin
        logic [31:0] rd, d;
        logic        err;
        int          w, nt, bad, op;

        // reset
        model_reset();
        #2 PRESETn = 0;
        repeat (3) @(negedge PCLK);
        check("rst_pready", PREADY, 0);
        check("rst_prdata", PRDATA, 0);
        check("rst_pslverr", PSLVERR, 0);
        check("rst_irq", irq, 0);
        check("rst_poll_tick", poll_tick, 0);
        check("rst_state", dbg_state, S_IDLE);
        PRESETn = 1;
        rd_chk("rst_status", 8'h04, exp_status(), 0, 0);
        rd_chk("rst_ctrl", 8'h00, 0, 0, 0);
        rd_chk("rst_polldiv", 8'h0C, 0, 0, 0);

        // CTRL write/read, zero wait
        wr_chk("ctrl_wr", 8'h00, 32'h3, 0);
        m_en = 1; m_irq_en = 1;
        rd_chk("ctrl_rd", 8'h00, 32'h3, 0, 0);

        // single sample through DATA with one wait state
        push_sample(32'hAABBCCDD);
        rd_chk("data_one", 8'h08, 32'hAABBCCDD, 0, 1);
        void'(exp_q.pop_front());
        rd_chk("status_empty", 8'h04, 32'h1, 0, 0);

        // overflow with five pushes into four entries
        for (int i = 0; i < 5; i++) push_sample($urandom);
        rd_chk("status_ovf", 8'h04, 32'h46, 0, 0);
        irq_chk("irq_ovf");
        wr_chk("status_w1c_other", 8'h04, 32'h3, 0);
        rd_chk("status_ovf_kept", 8'h04, exp_status(), 0, 0);
        wr_chk("status_w1c", 8'h04, 32'h4, 0);
        m_ovf = 0;
        rd_chk("status_ovf_clr", 8'h04, 32'h42, 0, 0);
        irq_chk("irq_nonempty");

        // full FIFO: pop and push in the same completing cycle
        d = $urandom;
        apb(0, 8'h08, 0, 1, d, rd, err, w);
        check("pushpop_data", rd, exp_q.pop_front());
        check("pushpop_err", err, 0);
        exp_q.push_back(d);
        rd_chk("pushpop_status", 8'h04, exp_status(), 0, 0);

        // error responses change nothing
        rd_chk("unmapped_10", 8'h10, 0, 1, 0);
        rd_chk("unmapped_1c", 8'h1C, 0, 1, 0);
        wr_chk("unmapped_hi", 8'h40, 32'h0, 1);
        rd_chk("ctrl_kept", 8'h00, 32'h3, 0, 0);
        wr_chk("data_write", 8'h08, 32'h1234, 1);
        rd_chk("status_kept", 8'h04, exp_status(), 0, 0);
        for (int i = 0; i < DEPTH; i++) rd_data("drain");
        rd_chk("data_empty", 8'h08, 0, 1, 1);
        rd_chk("status_drained", 8'h04, 32'h1, 0, 0);

        // flush with a push in the same cycle
        push_sample($urandom);
        push_sample($urandom);
        apb(1, 8'h00, 32'h7, 1, $urandom, rd, err, w);
        check("flush_err", err, 0);
        exp_q.delete();
        rd_chk("flush_ctrl", 8'h00, 32'h3, 0, 0);
        rd_chk("flush_status", 8'h04, exp_status(), 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 6);
            case (op)
                0, 1, 2: push_sample($urandom);
                3: rd_data("rnd_data");
                4: begin
                    rd_chk("rnd_status", 8'h04, exp_status(), 0, 0);
                    irq_chk("rnd_irq");
                end
                5: begin
                    d = 32'($urandom_range(0, 3));
                    wr_chk("rnd_ctrl", 8'h00, d, 0);
                    m_en = d[0]; m_irq_en = d[1];
                end
                default: begin
                    d = $urandom;
                    wr_chk("rnd_w1c", 8'h04, d, 0);
                    if (d[2]) m_ovf = 0;
                end
            endcase
        end
        rd_chk("rnd_final_status", 8'h04, exp_status(), 0, 0);

        // poll ticks
        wr_chk("poll_ctrl", 8'h00, 32'h1, 0);
        m_en = 1; m_irq_en = 0;
        wr_chk("poll_div", 8'h0C, 32'hFFFF0003, 0);
        rd_chk("poll_div_rd", 8'h0C, 32'h3, 0, 0);
        count_ticks(24, nt, bad, 4);
        check("poll_count", nt, 6);
        check("poll_gap", bad, 0);
        wr_chk("poll_dis", 8'h00, 32'h0, 0);
        m_en = 0;
        count_ticks(20, nt, bad, 4);
        check("poll_disabled", nt, 0);
        wr_chk("poll_en0", 8'h00, 32'h1, 0);
        m_en = 1;
        wr_chk("poll_div0", 8'h0C, 32'h0, 0);
        count_ticks(20, nt, bad, 1);
        check("poll_period0", nt, 0);

        // reset during a DATA-read WAIT
        exp_q.delete(); m_ovf = 0;
        wr_chk("pre_rst_flush", 8'h00, 32'h7, 0);
        m_en = 1; m_irq_en = 1;
        push_sample(32'h5A5A0001);
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h08;
        @(negedge PCLK);
        PENABLE = 1;
        @(negedge PCLK);
        check("wait_state", dbg_state, S_WAIT);
        PRESETn = 0;
        #1;
        check("rstw_pready", PREADY, 0);
        check("rstw_prdata", PRDATA, 0);
        check("rstw_pslverr", PSLVERR, 0);
        check("rstw_irq", irq, 0);
        check("rstw_poll_tick", poll_tick, 0);
        PSEL = 0; PENABLE = 0;
        model_reset();
        repeat (2) @(negedge PCLK);
        PRESETn = 1;
        @(negedge PCLK);
        check("rstw_state", dbg_state, S_IDLE);
        rd_chk("rstw_status", 8'h04, exp_status(), 0, 0);
        rd_chk("rstw_ctrl", 8'h00, 32'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
